// File: rtl/port_arbiter.sv
// Three-port round-robin word arbiter with burst limiting, a per-port mask and
// saturating per-port transfer counters behind a small host register window.
module port_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    output logic [2:0] ack,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_port,
    output logic [7:0] out_data,
    input  logic       chipselect,
    input  logic       read,
    input  logic       write,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0] state_r;
    logic [1:0] g_r;
    logic [1:0] last_r;
    logic [3:0] bcnt_r;
    logic [2:0] mask_r;
    logic [7:0] cnt_r [0:2];

    logic [2:0] gsel_s;
    logic [7:0] gdata_s;
    logic [2:0] eligible_s;
    logic [1:0] next_s;
    logic       in_xfer_s;
    logic       xfer_s;
    logic       leave_s;
    logic       clr_s;
    logic       mask_wr_s;
    logic       unused_wd_s;

    // First eligible port scanning last+1, last+2, last+3 with 1-based wrap.
    function automatic logic [1:0] pick_next(input logic [1:0] last, input logic [2:0] elig);
        logic [1:0] p;
        logic [1:0] found;
        p     = last;
        found = 2'd0;
        for (int k = 0; k < 3; k++) begin
            p = (p == 2'd3) ? 2'd1 : p + 2'd1;
            if (found == 2'd0 && elig[p - 2'd1]) begin
                found = p;
            end
        end
        return found;
    endfunction

    // Decode the registered grant into a one-hot select and its data word.
    always_comb begin
        gsel_s  = 3'b000;
        gdata_s = 8'h00;
        case (g_r)
            2'd1: begin gsel_s = 3'b001; gdata_s = data1; end
            2'd2: begin gsel_s = 3'b010; gdata_s = data2; end
            2'd3: begin gsel_s = 3'b100; gdata_s = data3; end
            default: begin gsel_s = 3'b000; gdata_s = 8'h00; end
        endcase
    end

    assign in_xfer_s   = (state_r == XFER);
    assign eligible_s  = req & mask_r;
    assign next_s      = pick_next(last_r, eligible_s);
    assign out_valid   = in_xfer_s & (|(req & mask_r & gsel_s));
    assign out_port    = in_xfer_s ? g_r : 2'd0;
    assign out_data    = in_xfer_s ? gdata_s : 8'h00;
    assign xfer_s      = out_valid & out_ready;
    assign ack         = xfer_s ? gsel_s : 3'b000;
    // Burst ends on the last permitted word, or as soon as the granted port stops qualifying.
    assign leave_s     = (xfer_s & (bcnt_r == 4'(MAX_BURST - 1))) | ~out_valid;
    assign clr_s       = chipselect & write & (address == 3'd4);
    assign mask_wr_s   = chipselect & write & (address == 3'd0);
    assign unused_wd_s = ^writedata[7:3];

    // Grant FSM: IDLE picks the next port, XFER streams words until the burst ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            g_r     <= 2'd0;
            last_r  <= 2'd3;
            bcnt_r  <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|eligible_s) begin
                        state_r <= XFER;
                        g_r     <= next_s;
                        last_r  <= next_s;
                        bcnt_r  <= 4'd0;
                    end
                end
                XFER: begin
                    if (leave_s) begin
                        state_r <= IDLE;
                        g_r     <= 2'd0;
                    end else if (xfer_s) begin
                        bcnt_r <= bcnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    g_r     <= 2'd0;
                end
            endcase
        end
    end

    // Host mask register and saturating per-port counters; a clear beats a coincident transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= 8'h00;
            end
        end else begin
            if (mask_wr_s) begin
                mask_r <= writedata[2:0];
            end
            for (int i = 0; i < 3; i++) begin
                if (clr_s) begin
                    cnt_r[i] <= 8'h00;
                end else if (ack[i] && cnt_r[i] != 8'hFF) begin
                    cnt_r[i] <= cnt_r[i] + 8'd1;
                end
            end
        end
    end

    // Registered host read; samples pre-write register values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 8'h00;
        end else if (chipselect && read) begin
            case (address)
                3'd0:    readdata <= {5'b00000, mask_r};
                3'd1:    readdata <= cnt_r[0];
                3'd2:    readdata <= cnt_r[1];
                3'd3:    readdata <= cnt_r[2];
                3'd4:    readdata <= {5'b00000, state_r, g_r};
                default: readdata <= 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_port_arbiter.sv
// Randomized scoreboard bench for port_arbiter: a transaction-level model predicts
// each cycle's output, a monitor compares the DUT against the queued predictions.
module tb_port_arbiter;

    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [7:0] data1, data2, data3;
    logic [2:0] ack;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_port;
    logic [7:0] out_data;
    logic       chipselect, read, write;
    logic [2:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;

    port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .req(req),
        .data1(data1), .data2(data2), .data3(data3),
        .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_port(out_port), .out_data(out_data),
        .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] ack;
        logic       v;
        logic [1:0] port;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ack2_seen = 0;

    // Reference model: granted port (0 = none), words left in burst, rotation pointer.
    int         m_g, m_left, m_last;
    logic [2:0] m_mask;
    int         m_cnt [1:3];
    logic [7:0] m_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_g = 0; m_left = 0; m_last = 3; m_mask = 3'b111; m_rd = 8'h00;
        for (int i = 1; i <= 3; i++) m_cnt[i] = 0;
    endtask

    // One clock of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic step(input logic [2:0] r, input logic rdy, input logic cs, input logic rd,
                        input logic wr, input logic [2:0] a, input logic [7:0] wd);
        exp_t       e;
        logic       valid, xf;
        logic [7:0] d [1:3];
        logic [2:0] elig;
        logic [1:0] gg;
        int         p;
        req = r; out_ready = rdy; chipselect = cs; read = rd; write = wr;
        address = a; writedata = wd;
        d[1] = 8'($urandom); d[2] = 8'($urandom); d[3] = 8'($urandom);
        data1 = d[1]; data2 = d[2]; data3 = d[3];
        valid = 1'b0;
        if (m_g != 0) valid = r[m_g-1] && m_mask[m_g-1];
        xf = valid && rdy;
        e.cyc  = cyc;
        e.v    = valid;
        e.port = 2'(m_g);
        e.data = (m_g != 0) ? d[m_g] : 8'h00;
        e.ack  = xf ? 3'(1 << (m_g - 1)) : 3'b000;
        sb.push_back(e);
        gg = 2'(m_g);
        if (cs && rd) begin
            case (a)
                3'd0: m_rd = {5'b00000, m_mask};
                3'd1, 3'd2, 3'd3: m_rd = 8'(m_cnt[a]);
                3'd4: m_rd = {5'b00000, (m_g != 0), gg};
                default: m_rd = 8'hFF;
            endcase
        end
        if (cs && wr && a == 3'd4) begin
            for (int i = 1; i <= 3; i++) m_cnt[i] = 0;
        end else if (xf) begin
            m_cnt[m_g] = (m_cnt[m_g] >= 255) ? 255 : m_cnt[m_g] + 1;
        end
        if (m_g == 0) begin
            elig = r & m_mask;
            for (int k = 1; k <= 3 && m_g == 0; k++) begin
                p = (m_last + k - 1) % 3 + 1;
                if (elig[p-1]) begin
                    m_g = p; m_last = p; m_left = MAX_BURST;
                end
            end
        end else if (!valid) begin
            m_g = 0;
        end else if (xf) begin
            m_left--;
            if (m_left == 0) m_g = 0;
        end
        if (cs && wr && a == 3'd0) m_mask = wd[2:0];
        @(posedge clk); #1;
        chk("readdata", readdata, m_rd);
    endtask

    task automatic idle(input logic [2:0] r, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(r, rdy, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic host_read(input logic [2:0] r, input logic [2:0] a);
        step(r, 1'b1, 1'b1, 1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic host_write(input logic [2:0] r, input logic [2:0] a, input logic [7:0] wd);
        step(r, 1'b1, 1'b1, 1'b0, 1'b1, a, wd);
    endtask

    // Keep stepping with request r until the model holds a grant to port p.
    task automatic wait_grant(input logic [2:0] r, input int p);
        int n;
        n = 0;
        while (m_g != p && n < 20) begin
            idle(r, 1'b1, 1);
            n++;
        end
        chk("grant_reached", m_g, p);
    endtask

    // Monitor: pops the prediction for the current cycle and compares outputs.
    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missed_cycle", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                chk("ack", ack, mon_e.ack);
                chk("out_valid", out_valid, mon_e.v);
                chk("out_port", out_port, mon_e.port);
                chk("out_data", out_data, mon_e.data);
            end else begin
                chk("idle_ack", ack, 0);
            end
            if (ack[1]) ack2_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a2;
        int x;
        reset = 1'b1; req = 3'b000; out_ready = 1'b0; chipselect = 1'b0; read = 1'b0;
        write = 1'b0; address = 3'd0; writedata = 8'h00; data1 = 8'h00; data2 = 8'h00; data3 = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_ack", ack, 0);
        chk("rst_readdata", readdata, 0);
        reset = 1'b0;

        // Full rotation at max rate: 1,2,3 each four words with an idle cycle between.
        idle(3'b111, 1'b1, 15);
        idle(3'b000, 1'b1, 1);
        host_read(3'b000, 3'd1); chk("cnt1_after_rotation", readdata, 4);
        host_read(3'b000, 3'd2); chk("cnt2_after_rotation", readdata, 4);
        host_read(3'b000, 3'd3); chk("cnt3_after_rotation", readdata, 4);

        // Single requester with back-pressure toggling every cycle.
        for (int i = 0; i < 24; i++) idle(3'b001, 1'(i % 2), 1);

        // Masking port2 out: only ports 1 and 3 are served.
        host_write(3'b111, 3'd0, 8'h05);
        a2 = ack2_seen;
        idle(3'b111, 1'b1, 40);
        chk("port2_masked_acks", ack2_seen - a2, 0);
        host_read(3'b000, 3'd0); chk("mask_read", readdata, 8'h05);
        host_write(3'b000, 3'd0, 8'h07);

        // Saturation, then a counter clear that coincides with a transfer.
        host_write(3'b000, 3'd4, 8'h00);
        idle(3'b001, 1'b1, 400);
        host_read(3'b000, 3'd1); chk("cnt1_saturated", readdata, 8'hFF);
        wait_grant(3'b001, 1);
        host_write(3'b001, 3'd4, 8'h00);
        host_read(3'b000, 3'd1); chk("cnt1_clear_wins", readdata, 8'h00);

        // Asynchronous reset in the middle of a port2 burst.
        idle(3'b000, 1'b1, 2);
        wait_grant(3'b010, 2);
        idle(3'b010, 1'b1, 1);
        chk("pre_reset_port", out_port, 2);
        reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_port", out_port, 0);
        chk("async_out_data", out_data, 0);
        chk("async_ack", ack, 0);
        model_reset();
        @(posedge clk); #1;
        chk("in_reset_ack", ack, 0);
        reset = 1'b0;
        host_read(3'b000, 3'd0); chk("mask_after_reset", readdata, 8'h07);
        idle(3'b111, 1'b1, 1);
        chk("first_grant_after_reset", out_port, 1);
        idle(3'b000, 1'b1, 3);

        // Unmapped address and status read during a port3 grant.
        host_read(3'b000, 3'd5); chk("addr5_read", readdata, 8'hFF);
        wait_grant(3'b100, 3);
        chk("port3_granted", out_port, 3);
        step(3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 8'h00);
        chk("status_xfer_g3", readdata, 8'h07);

        // Random traffic, back-pressure and host accesses.
        for (int i = 0; i < 2000; i++) begin
            x = $urandom_range(0, 15);
            case (x)
                0: host_write(3'($urandom), 3'd0, 8'($urandom));
                1: host_write(3'($urandom), 3'd4, 8'h00);
                2, 3: host_read(3'($urandom), 3'($urandom));
                4: step(3'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1, 3'($urandom), 8'($urandom));
                default: idle(3'($urandom), ($urandom_range(0, 3) != 0), 1);
            endcase
            if (i % 200 == 199) host_write(3'b000, 3'd0, 8'h07);
        end

        idle(3'b000, 1'b1, 2);
        @(negedge clk); #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
